pipe_hazard_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 17 +
 rtl/hazard_stage_reg.sv | 16 +
 rtl/pipe_hazard_unit.sv | 111 +++++++++++
 tb/tb_pipe_hazard_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the decode-side hazard logic: pipeline stage entry and hazard FSM states.
package cpu_pkg;
  localparam int REG_AW_DEF = 4;
  // Stage entries carry rd at this fixed width; narrower register files zero-extend.
  localparam int REG_AW_MAX = 8;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rd;
    logic                  we;
    logic                  is_load;
  } stage_t;

  localparam int STAGE_W = $bits(stage_t);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} haz_state_e;
endpackage

// File: rtl/hazard_stage_reg.sv
// One entry of the post-decode tracking chain: captures d when load is set, else a bubble.
module hazard_stage_reg
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [STAGE_W-1:0] d,
  output logic [STAGE_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
    else           q <= '0;
  end
endmodule

// File: rtl/pipe_hazard_unit.sv
// Load-use stall, forwarding select and HLT drain control for an in-order pipeline.
// Optional HAZ_PERF_CNT_EN adds saturating 16-bit stall/flush cycle counters.
module pipe_hazard_unit
  import cpu_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  localparam int FSW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              hlt_in,
  output logic              stall,
  output logic [FSW-1:0]    fwd_a_sel,
  output logic [FSW-1:0]    fwd_b_sel,
`ifdef HAZ_PERF_CNT_EN
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt,
`endif
  output logic              hlt
);
  stage_t [DEPTH:1] chain;
  logic   [DEPTH:1] vld_pipe;
  stage_t           id_ent;
  logic             s1_load;
  haz_state_e       state, state_nx;
  logic             a_ld, b_ld;
  logic [REG_AW_MAX-1:0] src_a, src_b;

  assign src_a  = REG_AW_MAX'(id_rs);
  assign src_b  = REG_AW_MAX'(id_rt);
  assign id_ent = '{valid: 1'b1, rd: REG_AW_MAX'(id_rd), we: id_we, is_load: id_is_load};

  // HLT never enters the chain, so draining only has to wait for older work.
  assign s1_load = id_valid & ~stall & ~flush & (state == RUN) & ~hlt_in;

  for (genvar g = 1; g <= DEPTH; g++) begin : g_stg
    assign vld_pipe[g] = chain[g].valid;
    if (g == 1) begin : g_head
      hazard_stage_reg u_stg (
        .clk(clk), .rst_n(rst_n), .load(s1_load), .d(id_ent), .q(chain[g])
      );
    end else begin : g_tail
      hazard_stage_reg u_stg (
        .clk(clk), .rst_n(rst_n), .load(1'b1), .d(chain[g-1]), .q(chain[g])
      );
    end
  end

  // Walk oldest to youngest so the youngest producer overwrites the selection.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    a_ld      = 1'b0;
    b_ld      = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (chain[k].valid && chain[k].we && id_rs_used && src_a != '0 && chain[k].rd == src_a) begin
        fwd_a_sel = FSW'(k);
        a_ld      = chain[k].is_load && (k < LOAD_LAT);
      end
      if (chain[k].valid && chain[k].we && id_rt_used && src_b != '0 && chain[k].rd == src_b) begin
        fwd_b_sel = FSW'(k);
        b_ld      = chain[k].is_load && (k < LOAD_LAT);
      end
    end
  end

  assign stall = id_valid & (state == RUN) & (a_ld | b_ld) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (hlt_in && id_valid && !stall && !flush) state_nx = DRAIN;
      DRAIN:   if (vld_pipe == '0) state_nx = HALTED;
      HALTED:  state_nx = HALTED;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hlt <= 1'b0;
    else        hlt <= (state_nx == HALTED);
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Randomized + directed bench for pipe_hazard_unit against an in-bench instruction-history model.
module tb_pipe_hazard_unit;
  localparam int REG_AW   = 4;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 2;
  localparam int FSW      = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              id_valid, id_rs_used, id_rt_used, id_we, id_is_load, flush, hlt_in;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              stall, hlt;
  logic [FSW-1:0]    fwd_a_sel, fwd_b_sel;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0]       stall_cnt, flush_cnt;
`endif

  pipe_hazard_unit #(.REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .flush(flush), .hlt_in(hlt_in), .stall(stall),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
`ifdef HAZ_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .hlt(hlt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: history of the last DEPTH issued instructions, age 1 = youngest.
  bit mv [1:DEPTH];
  int mrd[1:DEPTH];
  bit mwe[1:DEPTH];
  bit mld[1:DEPTH];
  int mst;            // 0 running, 1 draining, 2 halted
  bit m_es;
  int m_scnt, m_fcnt;

  function automatic int youngest(int src, bit used);
    for (int k = 1; k <= DEPTH; k++)
      if (mv[k] && mwe[k] && used && src != 0 && mrd[k] == src) return k;
    return 0;
  endfunction

  function automatic bit load_use(int k);
    return k != 0 && mld[k] && k < LOAD_LAT;
  endfunction

  task automatic drive(bit v, int rs, int rt, bit ru, bit rtu, int rd, bit we, bit ld, bit fl, bit h);
    id_valid = v;  id_rs = REG_AW'(rs); id_rt = REG_AW'(rt);
    id_rs_used = ru; id_rt_used = rtu; id_rd = REG_AW'(rd);
    id_we = we; id_is_load = ld; flush = fl; hlt_in = h;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_clear();
    for (int k = 1; k <= DEPTH; k++) begin
      mv[k] = 0; mrd[k] = 0; mwe[k] = 0; mld[k] = 0;
    end
    mst = 0; m_scnt = 0; m_fcnt = 0; m_es = 0;
  endtask

  task automatic sample(string tag);
    int ea, eb;
    @(negedge clk);
    ea   = youngest(int'(id_rs), id_rs_used);
    eb   = youngest(int'(id_rt), id_rt_used);
    m_es = id_valid && mst == 0 && (load_use(ea) || load_use(eb)) && !flush;
    chk({tag, ".stall"}, int'(stall), int'(m_es));
    chk({tag, ".fwd_a"}, int'(fwd_a_sel), ea);
    chk({tag, ".fwd_b"}, int'(fwd_b_sel), eb);
    chk({tag, ".hlt"}, int'(hlt), int'(mst == 2));
`ifdef HAZ_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, int'(stall_cnt), m_scnt);
    chk({tag, ".flush_cnt"}, int'(flush_cnt), m_fcnt);
`endif
  endtask

  task automatic advance();
    bit empty, enter;
    int nst;
    @(posedge clk);
    empty = 1;
    for (int k = 1; k <= DEPTH; k++) if (mv[k]) empty = 0;
    enter = id_valid && !m_es && !flush && mst == 0;
    nst = mst;
    if (mst == 0 && hlt_in && enter) nst = 1;
    else if (mst == 1 && empty)      nst = 2;
    for (int k = DEPTH; k >= 2; k--) begin
      mv[k] = mv[k-1]; mrd[k] = mrd[k-1]; mwe[k] = mwe[k-1]; mld[k] = mld[k-1];
    end
    mv[1]  = enter && !hlt_in;
    mrd[1] = mv[1] ? int'(id_rd) : 0;
    mwe[1] = mv[1] && id_we;
    mld[1] = mv[1] && id_is_load;
    if (m_es  && m_scnt < 65535) m_scnt++;
    if (flush && m_fcnt < 65535) m_fcnt++;
    mst = nst;
    #1;
  endtask

  task automatic cyc(string tag);
    sample(tag);
    advance();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    chk("rst.stall", int'(stall), 0);
    chk("rst.fwd_a", int'(fwd_a_sel), 0);
    chk("rst.fwd_b", int'(fwd_b_sel), 0);
    chk("rst.hlt", int'(hlt), 0);
`ifdef HAZ_PERF_CNT_EN
    chk("rst.stall_cnt", int'(stall_cnt), 0);
    chk("rst.flush_cnt", int'(flush_cnt), 0);
`endif
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    do_reset();

    // ALU result forwarded from EX to the immediately following consumer
    drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0); cyc("alu0");
    drive(1, 3, 1, 1, 1, 4, 1, 0, 0, 0); sample("alu1");
    chk("alu_fwd.fwd_a", int'(fwd_a_sel), 1);
    chk("alu_fwd.stall", int'(stall), 0);
    advance();

    // load-use: one stall cycle, then forward from stage 2
    drive(1, 1, 0, 1, 0, 5, 1, 1, 0, 0); cyc("lw0");
    drive(1, 5, 2, 1, 1, 6, 1, 0, 0, 0); sample("lu0");
    chk("lu.stall1", int'(stall), 1);
    advance();
    sample("lu1");
    chk("lu.stall2", int'(stall), 0);
    chk("lu.fwd_a", int'(fwd_a_sel), 2);
    advance();

    // youngest producer wins; r0 never forwards
    idle(); repeat (3) cyc("drain_a");
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); cyc("w3a");
    drive(1, 0, 0, 0, 0, 7, 0, 0, 0, 0); cyc("nw");
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); cyc("w3b");
    drive(1, 3, 3, 1, 1, 0, 1, 0, 0, 0); sample("rd3");
    chk("young.fwd_a", int'(fwd_a_sel), 1);
    chk("young.fwd_b", int'(fwd_b_sel), 1);
    advance();
    drive(1, 0, 0, 1, 1, 8, 1, 0, 0, 0); sample("rd0");
    chk("r0.fwd_a", int'(fwd_a_sel), 0);
    advance();

    // flush during a load-use stall: no stall, and the squashed op never enters
    idle(); repeat (3) cyc("drain_b");
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); cyc("lw1");
    drive(1, 5, 0, 1, 0, 5, 1, 0, 1, 0); sample("fl0");
    chk("flush.stall", int'(stall), 0);
    advance();
    drive(1, 5, 0, 1, 0, 9, 1, 0, 0, 0); sample("fl1");
    chk("flush.bubble_fwd", int'(fwd_a_sel), 2);
    advance();

    // HLT after three ALU ops: hlt rises 4 cycles after HLT decode and sticks
    idle(); repeat (3) cyc("drain_c");
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 10 + i, 1, 0, 0, 0); cyc("alu_h");
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); cyc("hlt0");
    drive(1, 1, 0, 1, 0, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      sample("hltw");
      chk("hlt.timing", int'(hlt), int'(i >= 4));
      advance();
    end
    do_reset();
    chk("hlt.after_rst", int'(hlt), 0);
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); cyc("run0");
    drive(1, 3, 0, 1, 0, 4, 1, 0, 0, 0); sample("run1");
    chk("run.fwd_a", int'(fwd_a_sel), 1);
    advance();

    // reset in the middle of a drain
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); cyc("md0");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); cyc("md1");
    do_reset();
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0); cyc("md2");
    drive(1, 0, 6, 0, 1, 7, 1, 0, 0, 0); sample("md3");
    chk("mid_drain.fwd_b", int'(fwd_b_sel), 1);
    chk("mid_drain.hlt", int'(hlt), 0);
    advance();

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0 || (mst == 2 && $urandom_range(0, 19) == 0)) do_reset();
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
            $urandom_range(0, 11) == 0, $urandom_range(0, 149) == 0);
      cyc("rnd");
    end

`ifdef HAZ_PERF_CNT_EN
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int n = 0; n < 70000; n++) advance();
    sample("sat");
    chk("sat.flush_cnt", int'(flush_cnt), 65535);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
